// File: rtl/cobalt_mult_pkg.sv
// cobalt_mult_pkg: shared defaults, stage record and latency limits for the multiply unit.
package cobalt_mult_pkg;
    localparam int MULT_DATA_W     = 32;
    localparam int MULT_TAG_W      = 6;
    localparam int MULT_STAGES     = 3;
    localparam int MULT_STAGES_MIN = 2;
    localparam int MULT_STAGES_MAX = 6;

    typedef struct packed {
        logic                   v;
        logic                   sgn;
        logic [MULT_TAG_W-1:0]  tag;
        logic [MULT_DATA_W-1:0] lo;
        logic [MULT_DATA_W-1:0] hi;
    } mult_stage_t;
endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one valid+payload pipeline register with load-enable and flush.
module mult_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         flush,
    input  logic         in_v,
    input  logic [W-1:0] in_data,
    output logic         out_v,
    output logic [W-1:0] out_data
);
    logic         v_d, v_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        v_d    = !flush && (load ? in_v : v_q);
        data_d = load ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_v    = v_q;
    assign out_data = data_q;
endmodule

// File: rtl/mult_exec_unit.sv
// mult_exec_unit: pipelined signed/unsigned multiplier with CDB hold, back-pressure and flush.
// Define MULT_HILO_EN to also register the upper product half and expose multcdb_hi.
module mult_exec_unit
    import cobalt_mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W,
    parameter int TAG_W  = MULT_TAG_W,
    parameter int STAGES = MULT_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issuemult_enable,
    output logic              issuemult_ready,
    input  logic              issuemult_signed,
    input  logic [DATA_W-1:0] issuemult_rsdata,
    input  logic [DATA_W-1:0] issuemult_rtdata,
    input  logic [TAG_W-1:0]  issuemult_rdtag,
    input  logic              flush,
    output logic              multcdb_valid,
    input  logic              multcdb_grant,
    output logic [DATA_W-1:0] multcdb_data,
`ifdef MULT_HILO_EN
    output logic [DATA_W-1:0] multcdb_hi,
`endif
    output logic [TAG_W-1:0]  multcdb_tag
);
    // Out-of-range depths are clamped to the supported latency window.
    localparam int NS = (STAGES < MULT_STAGES_MIN) ? MULT_STAGES_MIN :
                        (STAGES > MULT_STAGES_MAX) ? MULT_STAGES_MAX : STAGES;
`ifdef MULT_HILO_EN
    localparam int PW = 2 * DATA_W;
`else
    localparam int PW = DATA_W;
`endif
    localparam int SW = TAG_W + PW;
    localparam int IW = 1 + TAG_W + 2 * DATA_W;

    logic                v  [NS];
    logic                ld [NS];
    logic [SW-1:0]       sd [1:NS-1];
    logic [IW-1:0]       s0;
    logic                s0_sgn;
    logic [TAG_W-1:0]    s0_tag;
    logic [DATA_W-1:0]   s0_a, s0_b;
    logic [2*DATA_W-1:0] ext_a, ext_b;
    logic [PW-1:0]       prod;

    // A stage loads when empty or when its occupant moves on, so bubbles collapse.
    for (genvar k = 0; k < NS; k++) begin : g_ld
        if (k == NS - 1) begin : g_out
            assign ld[k] = !v[k] || multcdb_grant;
        end else begin : g_mid
            assign ld[k] = !v[k] || ld[k+1];
        end
    end

    mult_pipe_stage #(.W(IW)) u_s0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ld[0]),
        .flush    (flush),
        .in_v     (issuemult_enable && !flush),
        .in_data  ({issuemult_signed, issuemult_rdtag, issuemult_rsdata, issuemult_rtdata}),
        .out_v    (v[0]),
        .out_data (s0)
    );

    assign {s0_sgn, s0_tag, s0_a, s0_b} = s0;
    assign ext_a = {{DATA_W{s0_sgn & s0_a[DATA_W-1]}}, s0_a};
    assign ext_b = {{DATA_W{s0_sgn & s0_b[DATA_W-1]}}, s0_b};
    assign prod  = PW'(ext_a * ext_b);

    for (genvar k = 1; k < NS; k++) begin : g_stage
        logic [SW-1:0] din;
        if (k == 1) begin : g_first
            assign din = {s0_tag, prod};
        end else begin : g_carry
            assign din = sd[k-1];
        end
        mult_pipe_stage #(.W(SW)) u_s (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (ld[k]),
            .flush    (flush),
            .in_v     (v[k-1]),
            .in_data  (din),
            .out_v    (v[k]),
            .out_data (sd[k])
        );
    end

    assign issuemult_ready = ld[0];
    assign multcdb_valid   = v[NS-1];
`ifdef MULT_HILO_EN
    assign {multcdb_tag, multcdb_hi, multcdb_data} = sd[NS-1];
`else
    assign {multcdb_tag, multcdb_data} = sd[NS-1];
`endif
endmodule

// File: tb/tb_mult_exec_unit.sv
// tb_mult_exec_unit: scenario tasks plus a scoreboard for mult_exec_unit (STAGES=3).
// Builds with or without MULT_HILO_EN.
module tb_mult_exec_unit;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        issuemult_enable = 0;
    logic        issuemult_ready;
    logic        issuemult_signed = 0;
    logic [31:0] issuemult_rsdata = 0;
    logic [31:0] issuemult_rtdata = 0;
    logic [5:0]  issuemult_rdtag = 0;
    logic        flush = 0;
    logic        multcdb_valid;
    logic        multcdb_grant = 0;
    logic [31:0] multcdb_data;
    logic [5:0]  multcdb_tag;
`ifdef MULT_HILO_EN
    logic [31:0] multcdb_hi;
`endif

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;
    exp_t exp_q[$];

    mult_exec_unit #(.DATA_W(32), .TAG_W(6), .STAGES(3)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .issuemult_enable (issuemult_enable),
        .issuemult_ready  (issuemult_ready),
        .issuemult_signed (issuemult_signed),
        .issuemult_rsdata (issuemult_rsdata),
        .issuemult_rtdata (issuemult_rtdata),
        .issuemult_rdtag  (issuemult_rdtag),
        .flush            (flush),
        .multcdb_valid    (multcdb_valid),
        .multcdb_grant    (multcdb_grant),
        .multcdb_data     (multcdb_data),
`ifdef MULT_HILO_EN
        .multcdb_hi       (multcdb_hi),
`endif
        .multcdb_tag      (multcdb_tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic sg, input logic [5:0] tg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (sg) p = longint'($signed(a)) * longint'($signed(b));
        else    p = {32'b0, a} * {32'b0, b};
        return '{tag: tg, lo: p[31:0], hi: p[63:32]};
    endfunction

    // Scoreboard: handshakes are evaluated just before the edge that completes them.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset_n) exp_q.delete();
        else begin
            if (multcdb_valid && multcdb_grant) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got tag=%0d data=%h, required no output", multcdb_tag, multcdb_data);
                end else begin
                    e = exp_q.pop_front();
`ifdef MULT_HILO_EN
                    if (multcdb_tag !== e.tag || multcdb_data !== e.lo || multcdb_hi !== e.hi) begin
                        bad++;
                        $display("FAIL sb_result: got tag=%0d hi=%h lo=%h, required tag=%0d hi=%h lo=%h",
                                 multcdb_tag, multcdb_hi, multcdb_data, e.tag, e.hi, e.lo);
                    end
`else
                    if (multcdb_tag !== e.tag || multcdb_data !== e.lo) begin
                        bad++;
                        $display("FAIL sb_result: got tag=%0d lo=%h, required tag=%0d lo=%h",
                                 multcdb_tag, multcdb_data, e.tag, e.lo);
                    end
`endif
                end
            end
            if (flush) exp_q.delete();
            else if (issuemult_enable && issuemult_ready)
                exp_q.push_back(model(issuemult_signed, issuemult_rdtag, issuemult_rsdata, issuemult_rtdata));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sg, input logic [5:0] tg, input logic [31:0] a, input logic [31:0] b);
        issuemult_enable = 1;
        issuemult_signed = sg;
        issuemult_rdtag  = tg;
        issuemult_rsdata = a;
        issuemult_rtdata = b;
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (multcdb_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !multcdb_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (multcdb_valid !== 1'b0 || multcdb_data !== 32'h0 || multcdb_tag !== 6'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h, required 0/0/0", multcdb_valid, multcdb_data, multcdb_tag);
        end
        #21 reset_n = 1;
        tick;
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b1 || multcdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got ready=%b valid=%b, required 1/0", issuemult_ready, multcdb_valid);
        end
    endtask

    task automatic test_basic;
        tick;
        multcdb_grant = 1;
        issue(0, 5, 7, 6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (multcdb_valid !== 1'(i == 3)) begin
                bad++;
                $display("FAIL basic_valid cyc%0d: got %b, required %b", i, multcdb_valid, (i == 3));
            end
            if (i == 3) begin
                total++;
                if (multcdb_data !== 32'd42 || multcdb_tag !== 6'd5) begin
                    bad++;
                    $display("FAIL basic_result: got d=%0d t=%0d, required 42/5", multcdb_data, multcdb_tag);
                end
            end
            tick;
            if (i == 0) issuemult_enable = 0;
        end
    endtask

    task automatic test_signed;
        bit ok;
        tick;
        multcdb_grant = 1;
        issue(1, 9, 32'hFFFF_FFFD, 32'd4);
        tick;
        issue(0, 10, 32'hFFFF_FFFD, 32'd4);
        tick;
        issuemult_enable = 0;
        wait_out(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL signed_timeout: got no valid, required valid within 20 cycles");
        end else begin
            total++;
            if (multcdb_tag !== 6'd9 || multcdb_data !== 32'hFFFF_FFF4) begin
                bad++;
                $display("FAIL signed_lo: got t=%0d d=%h, required 9/fffffff4", multcdb_tag, multcdb_data);
            end
`ifdef MULT_HILO_EN
            total++;
            if (multcdb_hi !== 32'hFFFF_FFFF) begin
                bad++;
                $display("FAIL signed_hi: got %h, required ffffffff", multcdb_hi);
            end
`endif
            @(negedge clk);
            total++;
            if (multcdb_valid !== 1'b1 || multcdb_tag !== 6'd10 || multcdb_data !== 32'hFFFF_FFF4) begin
                bad++;
                $display("FAIL unsigned_lo: got v=%b t=%0d d=%h, required 1/10/fffffff4", multcdb_valid, multcdb_tag, multcdb_data);
            end
`ifdef MULT_HILO_EN
            total++;
            if (multcdb_hi !== 32'h0000_0003) begin
                bad++;
                $display("FAIL unsigned_hi: got %h, required 00000003", multcdb_hi);
            end
`endif
        end
    endtask

    task automatic test_back_pressure;
        logic [31:0] held;
        tick;
        multcdb_grant = 0;
        for (int t = 1; t <= 3; t++) begin
            issue(0, 6'(t), 32'(t + 10), 32'(t + 3));
            @(negedge clk);
            total++;
            if (issuemult_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_ready_accept%0d: got %b, required 1", t, issuemult_ready);
            end
            tick;
        end
        issue(0, 4, 14, 7);
        @(negedge clk);
        held = multcdb_data;
        total++;
        if (issuemult_ready !== 1'b0 || multcdb_valid !== 1'b1 || multcdb_tag !== 6'd1 || held !== 32'd44) begin
            bad++;
            $display("FAIL bp_full: got ready=%b v=%b t=%0d d=%0d, required 0/1/1/44", issuemult_ready, multcdb_valid, multcdb_tag, held);
        end
        tick;
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b0 || multcdb_tag !== 6'd1 || multcdb_data !== held) begin
            bad++;
            $display("FAIL bp_hold: got ready=%b t=%0d d=%0d, required 0/1/%0d", issuemult_ready, multcdb_tag, multcdb_data, held);
        end
        tick;
        multcdb_grant = 1;
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b1 || multcdb_tag !== 6'd1) begin
            bad++;
            $display("FAIL bp_grant_ready: got ready=%b t=%0d, required 1/1", issuemult_ready, multcdb_tag);
        end
        tick;
        issuemult_enable = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (multcdb_valid !== 1'b1 || multcdb_tag !== 6'(i + 2)) begin
                bad++;
                $display("FAIL bp_order%0d: got v=%b t=%0d, required 1/%0d", i, multcdb_valid, multcdb_tag, i + 2);
            end
            tick;
        end
    endtask

    task automatic test_bubble;
        bit ok;
        tick;
        multcdb_grant = 0;
        issue(0, 1, 3, 5);
        tick;
        issuemult_enable = 0;
        tick;
        tick;
        issue(0, 2, 6, 7);
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b1) begin
            bad++;
            $display("FAIL bubble_ready_issue: got %b, required 1", issuemult_ready);
        end
        tick;
        issuemult_enable = 0;
        tick;
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b1 || multcdb_valid !== 1'b1 || multcdb_tag !== 6'd1) begin
            bad++;
            $display("FAIL bubble_packed: got ready=%b v=%b t=%0d, required 1/1/1", issuemult_ready, multcdb_valid, multcdb_tag);
        end
        tick;
        multcdb_grant = 1;
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bubble_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush;
        int seen;
        tick;
        multcdb_grant = 0;
        for (int t = 1; t <= 3; t++) begin
            issue(0, 6'(t), 32'(t), 32'(t + 1));
            tick;
        end
        issue(0, 7, 9, 9);
        flush = 1;
        multcdb_grant = 1;
        @(negedge clk);
        total++;
        if (issuemult_ready !== 1'b1 || multcdb_valid !== 1'b1 || multcdb_tag !== 6'd1) begin
            bad++;
            $display("FAIL flush_cycle: got ready=%b v=%b t=%0d, required 1/1/1", issuemult_ready, multcdb_valid, multcdb_tag);
        end
        tick;
        flush = 0;
        issuemult_enable = 0;
        @(negedge clk);
        total++;
        if (multcdb_valid !== 1'b0 || issuemult_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_after: got v=%b ready=%b, required 0/1", multcdb_valid, issuemult_ready);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (multcdb_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL flush_quiet: got %0d valid cycles, required 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int seen;
        tick;
        multcdb_grant = 0;
        issue(0, 11, 5, 5);
        tick;
        issue(0, 12, 2, 9);
        tick;
        issuemult_enable = 0;
        wait_out(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_timeout: got no valid, required valid within 20 cycles");
        end
        #2;
        reset_n = 0;
        exp_q.delete();
        #1;
        total++;
        if (multcdb_valid !== 1'b0 || multcdb_data !== 32'h0 || multcdb_tag !== 6'h0) begin
            bad++;
            $display("FAIL rstmid_async: got v=%b d=%h t=%h, required 0/0/0", multcdb_valid, multcdb_data, multcdb_tag);
        end
        @(posedge clk);
        #2;
        reset_n = 1;
        tick;
        multcdb_grant = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (multcdb_valid) seen++;
        end
        total++;
        if (seen != 0 || issuemult_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_quiet: got %0d valid cycles ready=%b, required 0/1", seen, issuemult_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_back_pressure;
        test_bubble;
        test_flush;
        test_reset_mid;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
